// File: rtl/br_flow_xbar_rsp_return.sv
// Response-return path for a flow-controlled crossbar: per-target tag FIFOs record the
// originating initiator of each request, and per-initiator LRU arbiters route responses back.
module br_flow_xbar_rsp_return #(
    parameter int unsigned NumInitiators  = 2,
    parameter int unsigned NumTargets     = 2,
    parameter int unsigned Width          = 1,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned SrcIdWidth    = $clog2(NumInitiators),
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NumTargets-1:0]                     req_valid,
    input  logic [NumTargets-1:0][SrcIdWidth-1:0]     req_src_id,
    output logic [NumTargets-1:0]                     req_ready,
    input  logic [NumTargets-1:0]                     rsp_push_valid,
    output logic [NumTargets-1:0]                     rsp_push_ready,
    input  logic [NumTargets-1:0][Width-1:0]          rsp_push_data,
    output logic [NumInitiators-1:0]                  rsp_pop_valid,
    input  logic [NumInitiators-1:0]                  rsp_pop_ready,
    output logic [NumInitiators-1:0][Width-1:0]       rsp_pop_data,
    output logic [NumTargets-1:0][CntWidth-1:0]       outstanding_count
);

    localparam int unsigned PtrWidth   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned TgtIdWidth = $clog2(NumTargets);

    logic [NumTargets-1:0][MaxOutstanding-1:0][SrcIdWidth-1:0] r_tags;
    logic [NumTargets-1:0][PtrWidth-1:0]                       r_wptr;
    logic [NumTargets-1:0][PtrWidth-1:0]                       r_rptr;
    logic [NumTargets-1:0][CntWidth-1:0]                       r_count;
    // r_order[i][k] is the target holding priority slot k for initiator i (slot 0 highest)
    logic [NumInitiators-1:0][NumTargets-1:0][TgtIdWidth-1:0]  r_order;
    logic [NumInitiators-1:0][NumTargets-1:0][TgtIdWidth-1:0]  w_order_nxt;

    logic [NumInitiators-1:0][NumTargets-1:0] w_req;
    logic [NumInitiators-1:0][NumTargets-1:0] w_gnt;
    logic [NumTargets-1:0]                    w_enq;
    logic [NumTargets-1:0]                    w_nonempty;
    logic [NumTargets-1:0][SrcIdWidth-1:0]    w_head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Tag FIFO status; a full FIFO stays not-ready even when popping this cycle
    always_comb begin
        w_nonempty = '0;
        w_head     = '0;
        req_ready  = '0;
        w_enq      = '0;
        for (int t = 0; t < NumTargets; t++) begin
            w_nonempty[t] = (r_count[t] != '0);
            w_head[t]     = r_tags[t][r_rptr[t]];
            req_ready[t]  = !rst && (r_count[t] < CntWidth'(MaxOutstanding));
            w_enq[t]      = req_valid[t] && req_ready[t];
        end
    end

    // Each target requests only the initiator named by its head tag
    always_comb begin
        w_req = '0;
        for (int t = 0; t < NumTargets; t++) begin
            for (int i = 0; i < NumInitiators; i++) begin
                w_req[i][t] = !rst && rsp_push_valid[t] && w_nonempty[t]
                              && (w_head[t] == SrcIdWidth'(i));
            end
        end
    end

    always_comb begin : arb
        logic                  found;
        logic [TgtIdWidth-1:0] gpos;
        w_gnt       = '0;
        w_order_nxt = r_order;
        found       = 1'b0;
        gpos        = '0;
        for (int i = 0; i < NumInitiators; i++) begin
            found = 1'b0;
            gpos  = '0;
            for (int k = 0; k < NumTargets; k++) begin
                if (!found && w_req[i][r_order[i][k]]) begin
                    found = 1'b1;
                    gpos  = TgtIdWidth'(k);
                end
            end
            if (found) begin
                w_gnt[i][r_order[i][gpos]] = 1'b1;
            end
            // On transfer the winner drops to the last slot; lower slots shift up by one
            if (found && rsp_pop_ready[i]) begin
                for (int k = 0; k < NumTargets - 1; k++) begin
                    if (TgtIdWidth'(k) >= gpos) begin
                        w_order_nxt[i][k] = r_order[i][k+1];
                    end
                end
                w_order_nxt[i][NumTargets-1] = r_order[i][gpos];
            end
        end
    end

    // Cut-through response path
    always_comb begin
        rsp_pop_valid  = '0;
        rsp_pop_data   = '0;
        rsp_push_ready = '0;
        for (int i = 0; i < NumInitiators; i++) begin
            rsp_pop_valid[i] = |w_req[i];
            for (int t = 0; t < NumTargets; t++) begin
                if (w_gnt[i][t]) begin
                    rsp_pop_data[i] = rsp_push_data[t];
                    if (rsp_pop_ready[i]) begin
                        rsp_push_ready[t] = 1'b1;
                    end
                end
            end
        end
    end

    assign outstanding_count = r_count;

    always_ff @(posedge clk) begin
        for (int t = 0; t < NumTargets; t++) begin
            if (!rst && w_enq[t]) begin
                r_tags[t][r_wptr[t]] <= req_src_id[t];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < NumInitiators; i++) begin
                for (int k = 0; k < NumTargets; k++) begin
                    r_order[i][k] <= TgtIdWidth'(k);
                end
            end
        end else begin
            for (int t = 0; t < NumTargets; t++) begin
                if (w_enq[t]) begin
                    r_wptr[t] <= ptr_inc(r_wptr[t]);
                end
                if (rsp_push_ready[t]) begin
                    r_rptr[t] <= ptr_inc(r_rptr[t]);
                end
                if (w_enq[t] && !rsp_push_ready[t]) begin
                    r_count[t] <= r_count[t] + CntWidth'(1);
                end else if (!w_enq[t] && rsp_push_ready[t]) begin
                    r_count[t] <= r_count[t] - CntWidth'(1);
                end
            end
            r_order <= w_order_nxt;
        end
    end

    // Protocol and structural invariants
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NumTargets; t++) begin
                assert (r_count[t] <= CntWidth'(MaxOutstanding));
                assert (!(req_valid[t] && !req_ready[t]));
                assert (!(rsp_push_valid[t] && !w_nonempty[t]));
            end
            for (int i = 0; i < NumInitiators; i++) begin
                assert ($onehot0(w_gnt[i]));
            end
        end
    end

endmodule

// File: tb/tb_br_flow_xbar_rsp_return.sv
// Directed bench for br_flow_xbar_rsp_return: expected responses are queued per initiator
// by the stimulus thread and checked by a negedge monitor on every rsp_pop transfer.
module tb_br_flow_xbar_rsp_return;

    localparam int unsigned NI = 2;
    localparam int unsigned NT = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned MO = 4;
    localparam int unsigned SW = 1;
    localparam int unsigned CW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NT-1:0]          req_valid;
    logic [NT-1:0][SW-1:0]  req_src_id;
    logic [NT-1:0]          req_ready;
    logic [NT-1:0]          rsp_push_valid;
    logic [NT-1:0]          rsp_push_ready;
    logic [NT-1:0][W-1:0]   rsp_push_data;
    logic [NI-1:0]          rsp_pop_valid;
    logic [NI-1:0]          rsp_pop_ready;
    logic [NI-1:0][W-1:0]   rsp_pop_data;
    logic [NT-1:0][CW-1:0]  outstanding_count;

    typedef struct {
        logic [W-1:0] data;
        int           tgt;
    } exp_t;

    exp_t exp_q[NI][$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    br_flow_xbar_rsp_return #(
        .NumInitiators (NI),
        .NumTargets    (NT),
        .Width         (W),
        .MaxOutstanding(MO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_src_id       (req_src_id),
        .req_ready        (req_ready),
        .rsp_push_valid   (rsp_push_valid),
        .rsp_push_ready   (rsp_push_ready),
        .rsp_push_data    (rsp_push_data),
        .rsp_pop_valid    (rsp_pop_valid),
        .rsp_pop_ready    (rsp_pop_ready),
        .rsp_pop_data     (rsp_pop_data),
        .outstanding_count(outstanding_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic expect_rsp(input int init, input logic [W-1:0] data, input int tgt);
        exp_t e;
        e.data = data;
        e.tgt  = tgt;
        exp_q[init].push_back(e);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = '0;
        rsp_push_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every transfer must match the oldest expected response for its initiator
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (rsp_pop_valid[i] && rsp_pop_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp init%0d: got data 0x%0h expected none", i, rsp_pop_data[i]);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check($sformatf("rsp_data_init%0d", i), 32'(rsp_pop_data[i]), 32'(mon_e.data));
                        check($sformatf("rsp_src_tgt%0d_init%0d", mon_e.tgt, i),
                              32'(rsp_push_ready[mon_e.tgt]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        req_valid      = '0;
        req_src_id     = '0;
        rsp_push_valid = '0;
        rsp_push_data  = '0;
        rsp_pop_ready  = '1;

        // Reset: outputs gated even with responses presented
        step();
        rsp_push_valid = 2'b11;
        at_sample();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_pop_valid", 32'(rsp_pop_valid), 32'h0);
        check("rst_push_ready", 32'(rsp_push_ready), 32'h0);
        check("rst_pop_data", 32'(rsp_pop_data), 32'h0);
        rsp_push_valid = '0;
        step();
        rst = 1'b0;
        at_sample();
        check("post_rst_req_ready", 32'(req_ready), 32'h3);
        check("post_rst_count", 32'(outstanding_count), 32'h0);

        // Single path: target 1 -> initiator 0
        step();
        req_valid     = 2'b10;
        req_src_id[1] = 1'b0;
        step();
        req_valid         = '0;
        rsp_push_valid    = 2'b10;
        rsp_push_data[1]  = 4'h5;
        expect_rsp(0, 4'h5, 1);
        at_sample();
        check("single_count1", 32'(outstanding_count[1]), 32'd1);
        check("single_pop_valid", 32'(rsp_pop_valid), 32'h1);
        check("single_pop_data0", 32'(rsp_pop_data[0]), 32'h5);
        check("single_pop_data1", 32'(rsp_pop_data[1]), 32'h0);
        check("single_push_ready", 32'(rsp_push_ready), 32'h2);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("single_count_after", 32'(outstanding_count[1]), 32'd0);

        // Ordering: target 0 tags 1,0,1
        step();
        req_valid     = 2'b01;
        req_src_id[0] = 1'b1;
        step();
        req_src_id[0] = 1'b0;
        step();
        req_src_id[0] = 1'b1;
        step();
        req_valid        = '0;
        rsp_push_valid   = 2'b01;
        rsp_push_data[0] = 4'hA;
        expect_rsp(1, 4'hA, 0);
        at_sample();
        check("order_a_valid", 32'(rsp_pop_valid), 32'h2);
        step();
        rsp_push_data[0] = 4'hB;
        expect_rsp(0, 4'hB, 0);
        at_sample();
        check("order_b_valid", 32'(rsp_pop_valid), 32'h1);
        step();
        rsp_push_data[0] = 4'hC;
        expect_rsp(1, 4'hC, 0);
        at_sample();
        check("order_c_valid", 32'(rsp_pop_valid), 32'h2);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("order_count", 32'(outstanding_count), 32'h0);

        // Contention from fresh LRU: t0, t1, t0
        do_reset();
        req_valid  = 2'b11;
        req_src_id = '0;
        step();
        req_valid = 2'b01;
        step();
        req_valid        = '0;
        rsp_push_valid   = 2'b11;
        rsp_push_data[0] = 4'h1;
        rsp_push_data[1] = 4'h2;
        expect_rsp(0, 4'h1, 0);
        at_sample();
        check("cont_count", 32'(outstanding_count), 32'({3'd1, 3'd2}));
        check("cont_gnt0", 32'(rsp_push_ready), 32'h1);
        step();
        rsp_push_data[0] = 4'h3;
        expect_rsp(0, 4'h2, 1);
        at_sample();
        check("cont_gnt1", 32'(rsp_push_ready), 32'h2);
        step();
        rsp_push_valid = 2'b01;
        expect_rsp(0, 4'h3, 0);
        at_sample();
        check("cont_gnt2", 32'(rsp_push_ready), 32'h1);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("cont_count_end", 32'(outstanding_count), 32'h0);

        // Backpressure: grant held on t0, no LRU update, no dequeue
        do_reset();
        req_valid  = 2'b11;
        req_src_id = '0;
        step();
        req_valid        = '0;
        rsp_push_valid   = 2'b11;
        rsp_push_data[0] = 4'h4;
        rsp_push_data[1] = 4'h6;
        rsp_pop_ready    = 2'b10;
        for (int c = 0; c < 3; c++) begin
            at_sample();
            check($sformatf("bp_valid_c%0d", c), 32'(rsp_pop_valid[0]), 32'd1);
            check($sformatf("bp_data_c%0d", c), 32'(rsp_pop_data[0]), 32'h4);
            check($sformatf("bp_push_ready_c%0d", c), 32'(rsp_push_ready), 32'h0);
            check($sformatf("bp_count_c%0d", c), 32'(outstanding_count), 32'({3'd1, 3'd1}));
            step();
        end
        rsp_pop_ready = 2'b11;
        expect_rsp(0, 4'h4, 0);
        at_sample();
        check("bp_release_t0", 32'(rsp_push_ready), 32'h1);
        step();
        rsp_push_valid = 2'b10;
        expect_rsp(0, 4'h6, 1);
        at_sample();
        check("bp_release_t1", 32'(rsp_push_ready), 32'h2);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("bp_count_end", 32'(outstanding_count), 32'h0);

        // Full FIFO on target 0
        step();
        req_valid     = 2'b01;
        req_src_id[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_sample();
            check($sformatf("fill_ready_c%0d", c), 32'(req_ready[0]), 32'd1);
            step();
        end
        req_valid = '0;
        at_sample();
        check("full_req_ready", 32'(req_ready), 32'h2);
        check("full_count", 32'(outstanding_count[0]), 32'd4);
        step();
        rsp_push_valid   = 2'b01;
        rsp_push_data[0] = 4'h7;
        expect_rsp(1, 4'h7, 0);
        at_sample();
        check("full_deq_ready_same", 32'(req_ready[0]), 32'd0);
        check("full_deq_push_ready", 32'(rsp_push_ready), 32'h1);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("full_deq_ready_next", 32'(req_ready[0]), 32'd1);
        check("full_deq_count", 32'(outstanding_count[0]), 32'd3);

        // Reset mid-flight with a stalled grant pending
        step();
        rsp_push_valid   = 2'b01;
        rsp_push_data[0] = 4'h8;
        rsp_pop_ready    = 2'b01;
        at_sample();
        check("mid_pending_valid", 32'(rsp_pop_valid), 32'h2);
        check("mid_pending_push_ready", 32'(rsp_push_ready), 32'h0);
        step();
        rst = 1'b1;
        at_sample();
        check("mid_rst_pop_valid", 32'(rsp_pop_valid), 32'h0);
        check("mid_rst_push_ready", 32'(rsp_push_ready), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        step();
        rst            = 1'b0;
        rsp_push_valid = '0;
        rsp_pop_ready  = 2'b11;
        at_sample();
        check("mid_post_count", 32'(outstanding_count), 32'h0);
        check("mid_post_req_ready", 32'(req_ready), 32'h3);

        // LRU for initiator 1 restored: t0 wins first again
        step();
        req_valid  = 2'b11;
        req_src_id = 2'b11;
        step();
        req_valid        = '0;
        rsp_push_valid   = 2'b11;
        rsp_push_data[0] = 4'h9;
        rsp_push_data[1] = 4'hE;
        expect_rsp(1, 4'h9, 0);
        at_sample();
        check("lru_rst_gnt_t0", 32'(rsp_push_ready), 32'h1);
        check("lru_rst_data", 32'(rsp_pop_data[1]), 32'h9);
        step();
        rsp_push_valid = 2'b10;
        expect_rsp(1, 4'hE, 1);
        at_sample();
        check("lru_rst_gnt_t1", 32'(rsp_push_ready), 32'h2);
        step();
        rsp_push_valid = '0;
        at_sample();
        check("end_count", 32'(outstanding_count), 32'h0);
        check("end_q0_empty", 32'(exp_q[0].size()), 32'd0);
        check("end_q1_empty", 32'(exp_q[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
